// File: rtl/perf_window_ctrl.sv
// rtl/perf_window_ctrl.sv - windowed total/recovery cycle counter with restoring-divide overhead percentage
module perf_window_ctrl #(
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] cfg_window_len,
    input  logic        recovery_active,
    input  logic        result_ready,
    output logic        busy,
    output logic        result_valid,
    output logic [7:0]  result_pct,
    output logic [31:0] result_total,
    output logic [31:0] result_recov,
    output logic        early_stop,
    output logic [15:0] window_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_DIVIDE,
        S_HOLD
    } state_t;

    state_t      state, state_nx;
    logic [31:0] len_q;
    logic [31:0] total_q;
    logic [31:0] recov_q;
    logic        early_q;
    logic [31:0] rem_q;
    logic [6:0]  low_q;
    logic [6:0]  quot_q;
    logic [2:0]  iter_q;

    logic [31:0] total_inc;
    logic [31:0] recov_inc;
    logic        term_hit;
    logic        window_end;
    logic [38:0] dividend;
    logic [32:0] trial;
    logic        trial_ge;
    logic [31:0] trial_sub;
    logic        handshake;
    logic        open_window;
    logic        div_last;

    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_HOLD);
    assign handshake    = result_valid && result_ready;
    assign div_last     = (iter_q == 3'd6);

    always_comb begin
        total_inc   = total_q + 32'd1;
        recov_inc   = recov_q + {31'd0, recovery_active};
        term_hit    = (total_inc == len_q);
        window_end  = term_hit || stop;
        // recov*100 as shift-adds: 64 + 32 + 4
        dividend    = ({7'd0, recov_inc} << 6) + ({7'd0, recov_inc} << 5) + ({7'd0, recov_inc} << 2);
        trial       = {rem_q, low_q[6]};
        trial_ge    = (trial >= {1'b0, total_q});
        trial_sub   = trial[31:0] - total_q;
        open_window = (cfg_window_len != 32'd0) &&
                      (((state == S_IDLE) && start) ||
                       ((state == S_HOLD) && handshake && AUTO_RESTART));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (open_window) state_nx = S_MEASURE;
            S_MEASURE: if (window_end) state_nx = S_DIVIDE;
            S_DIVIDE:  if (div_last) state_nx = S_HOLD;
            S_HOLD:    if (handshake) state_nx = open_window ? S_MEASURE : S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q        <= 32'd0;
            total_q      <= 32'd0;
            recov_q      <= 32'd0;
            early_q      <= 1'b0;
            rem_q        <= 32'd0;
            low_q        <= 7'd0;
            quot_q       <= 7'd0;
            iter_q       <= 3'd0;
            result_pct   <= 8'd0;
            result_total <= 32'd0;
            result_recov <= 32'd0;
            early_stop   <= 1'b0;
            window_count <= 16'd0;
        end else begin
            if (open_window) begin
                len_q   <= cfg_window_len;
                total_q <= 32'd0;
                recov_q <= 32'd0;
            end
            if (state == S_MEASURE) begin
                total_q <= total_inc;
                recov_q <= recov_inc;
                if (window_end) begin
                    // quotient <= 100 < 128 guarantees the top 32 bits are already below the divisor
                    rem_q   <= dividend[38:7];
                    low_q   <= dividend[6:0];
                    quot_q  <= 7'd0;
                    iter_q  <= 3'd0;
                    early_q <= stop && !term_hit;
                end
            end
            if (state == S_DIVIDE) begin
                rem_q  <= trial_ge ? trial_sub : trial[31:0];
                low_q  <= {low_q[5:0], 1'b0};
                quot_q <= {quot_q[5:0], trial_ge};
                iter_q <= iter_q + 3'd1;
                if (div_last) begin
                    result_pct   <= {1'b0, quot_q[5:0], trial_ge};
                    result_total <= total_q;
                    result_recov <= recov_q;
                    early_stop   <= early_q;
                    window_count <= window_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_perf_window_ctrl.sv
// tb/tb_perf_window_ctrl.sv - scoreboard bench for perf_window_ctrl, manual and auto-restart instances
`timescale 1ns/1ps
module tb_perf_window_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0, start0, stop0, ra0, rdy0;
    logic [31:0] cfg0;
    logic        busy0, val0, early0;
    logic [7:0]  pct0;
    logic [31:0] tot0, rec0;
    logic [15:0] wc0;

    logic        reset1, start1, stop1, ra1, rdy1;
    logic [31:0] cfg1;
    logic        busy1, val1, early1;
    logic [7:0]  pct1;
    logic [31:0] tot1, rec1;
    logic [15:0] wc1;

    perf_window_ctrl #(.AUTO_RESTART(1'b0)) dut0 (
        .clk(clk), .reset(reset0), .start(start0), .stop(stop0),
        .cfg_window_len(cfg0), .recovery_active(ra0), .result_ready(rdy0),
        .busy(busy0), .result_valid(val0), .result_pct(pct0),
        .result_total(tot0), .result_recov(rec0), .early_stop(early0),
        .window_count(wc0)
    );

    perf_window_ctrl #(.AUTO_RESTART(1'b1)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .stop(stop1),
        .cfg_window_len(cfg1), .recovery_active(ra1), .result_ready(rdy1),
        .busy(busy1), .result_valid(val1), .result_pct(pct1),
        .result_total(tot1), .result_recov(rec1), .early_stop(early1),
        .window_count(wc1)
    );

    typedef struct packed {
        logic [7:0]  pct;
        logic [31:0] tot;
        logic [31:0] rec;
        logic        early;
        logic [15:0] wc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic pv0 = 1'b0;
    logic pv1 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: pop and compare on each rising result_valid
    always @(negedge clk) begin
        if (val0 && !pv0) begin
            if (q0.size() == 0) chk("sb0_unexpected", 64'd1, 64'd0);
            else begin
                m0 = q0.pop_front();
                chk("sb0_pct", pct0, m0.pct);
                chk("sb0_total", tot0, m0.tot);
                chk("sb0_recov", rec0, m0.rec);
                chk("sb0_early", early0, m0.early);
                chk("sb0_wcount", wc0, m0.wc);
            end
        end
        if (val1 && !pv1) begin
            if (q1.size() == 0) chk("sb1_unexpected", 64'd1, 64'd0);
            else begin
                m1 = q1.pop_front();
                chk("sb1_pct", pct1, m1.pct);
                chk("sb1_total", tot1, m1.tot);
                chk("sb1_recov", rec1, m1.rec);
                chk("sb1_early", early1, m1.early);
                chk("sb1_wcount", wc1, m1.wc);
            end
        end
        pv0 = val0;
        pv1 = val1;
    end

    task automatic wait_valid0(output int cyc);
        cyc = 0;
        while (!val0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // pat bit j-1 drives recovery_active for counted cycle j; k>0 asserts stop on cycle k
    task automatic run0(input int L, input logic [127:0] pat, input int k, input int hold,
                        input logic [7:0] ep, input logic [31:0] et, input logic [31:0] er,
                        input logic ee, input logic [15:0] ewc);
        int n_end, cyc;
        logic bad;
        q0.push_back({ep, et, er, ee, ewc});
        n_end = (k > 0) ? k : L;
        @(posedge clk); #1;
        start0 = 1'b1; cfg0 = L; ra0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("busy_after_start", busy0, 1'b1);
        for (int j = 1; j <= n_end; j++) begin
            ra0 = pat[j-1];
            stop0 = (j == k);
            @(posedge clk); #1;
        end
        ra0 = 1'b1; stop0 = 1'b0;
        wait_valid0(cyc);
        chk("valid_latency", cyc, 7);
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start0 = (i == 5);
            @(posedge clk); #1;
            if (!(val0 && busy0 && pct0 == ep && tot0 == et && rec0 == er &&
                  early0 == ee && wc0 == ewc)) bad = 1'b1;
        end
        start0 = 1'b0;
        if (hold > 0) chk("hold_stable", bad, 1'b0);
        rdy0 = 1'b1;
        @(posedge clk); #1;
        rdy0 = 1'b0;
        chk("valid_drop", val0, 1'b0);
        chk("busy_drop", busy0, 1'b0);
        chk("pct_retained", pct0, ep);
        chk("wcount_retained", wc0, ewc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        reset0 = 1'b1; start0 = 1'b0; stop0 = 1'b0; ra0 = 1'b0; rdy0 = 1'b0; cfg0 = 32'd0;
        reset1 = 1'b1; start1 = 1'b0; stop1 = 1'b0; ra1 = 1'b0; rdy1 = 1'b0; cfg1 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 1'b0);
        chk("rst_valid", val0, 1'b0);
        chk("rst_pct", pct0, 8'd0);
        chk("rst_total", tot0, 32'd0);
        chk("rst_recov", rec0, 32'd0);
        chk("rst_early", early0, 1'b0);
        chk("rst_wcount", wc0, 16'd0);
        reset0 = 1'b0; reset1 = 1'b0;

        run0(10,  128'b1000100010, 0, 0,  8'd30,  32'd10, 32'd3, 1'b0, 16'd1);
        run0(7,   128'b0000001,    0, 0,  8'd14,  32'd7,  32'd1, 1'b0, 16'd2);
        run0(3,   128'b111,        0, 0,  8'd100, 32'd3,  32'd3, 1'b0, 16'd3);
        run0(5,   128'b00000,      0, 0,  8'd0,   32'd5,  32'd0, 1'b0, 16'd4);
        run0(100, 128'b0101,       4, 0,  8'd50,  32'd4,  32'd2, 1'b1, 16'd5);
        run0(6,   128'b000001,     6, 0,  8'd16,  32'd6,  32'd1, 1'b0, 16'd6);
        run0(4,   128'b0011,       0, 20, 8'd50,  32'd4,  32'd2, 1'b0, 16'd7);

        // zero length is refused
        @(posedge clk); #1;
        cfg0 = 32'd0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("zero_len_busy", busy0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_len_busy_later", busy0, 1'b0);

        // reset in the middle of a division
        cfg0 = 32'd5; start0 = 1'b1; ra0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy0, 1'b1);
        reset0 = 1'b1;
        #1;
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_valid", val0, 1'b0);
        chk("midrst_pct", pct0, 8'd0);
        chk("midrst_total", tot0, 32'd0);
        chk("midrst_recov", rec0, 32'd0);
        chk("midrst_early", early0, 1'b0);
        chk("midrst_wcount", wc0, 16'd0);
        @(posedge clk); #1;
        reset0 = 1'b0;
        run0(4, 128'b0001, 0, 0, 8'd25, 32'd4, 32'd1, 1'b0, 16'd1);

        // auto-restart instance
        q1.push_back({8'd33, 32'd3, 32'd1, 1'b0, 16'd1});
        q1.push_back({8'd0,  32'd3, 32'd0, 1'b0, 16'd2});
        @(posedge clk); #1;
        cfg1 = 32'd3; start1 = 1'b1; ra1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b0; ra1 = 1'b1;
        @(posedge clk); #1;
        ra1 = 1'b0;
        cyc = 0;
        while (!val1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("auto_first_latency", cyc, 9);
        rdy1 = 1'b1;
        @(posedge clk); #1;
        rdy1 = 1'b0;
        chk("auto_valid_drop", val1, 1'b0);
        chk("auto_busy_stays", busy1, 1'b1);
        cyc = 0;
        while (!val1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("auto_restart_latency", cyc, 10);
        cfg1 = 32'd0; rdy1 = 1'b1;
        @(posedge clk); #1;
        rdy1 = 1'b0;
        chk("auto_zero_len_idle", busy1, 1'b0);
        chk("auto_final_valid", val1, 1'b0);
        chk("auto_final_wcount", wc1, 16'd2);

        repeat (2) @(posedge clk);
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
